// File: rtl/packman_sprite_fetch.sv
// Sprite fetch stage for Pac-Man: maps the draw coordinate to a sprite-ROM address,
// registers the ROM colour index with an opaque-hit flag, and runs the chomp animation.
module packman_sprite_fetch #(
    parameter int unsigned SPR_W      = 16,
    parameter int unsigned SPR_H      = 16,
    parameter int unsigned NUM_FRAMES = 3,
    parameter int unsigned FRAME_DIV  = 4,
    parameter int unsigned TRANS_IDX  = 8,
    parameter int unsigned ADDR_W     = 12
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank_n,
    input  logic              vsync,
    input  logic [9:0]        PacX,
    input  logic [9:0]        PacY,
    input  logic [1:0]        dir,
    input  logic              moving,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [3:0]        index,
    output logic              hit,
    output logic [1:0]        frame
);

    localparam int unsigned     DIV_W      = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(FRAME_DIV - 1);
    localparam logic [1:0]      FRAME_LAST = 2'(NUM_FRAMES - 1);
    localparam logic [3:0]      TRANS_V    = 4'(TRANS_IDX);
    localparam logic [10:0]     SPR_W11    = 11'(SPR_W);
    localparam logic [10:0]     SPR_H11    = 11'(SPR_H);

    logic [9:0]        col_s;
    logic [9:0]        row_s;
    logic              in_box_s;
    logic              vs_edge_s;
    logic [ADDR_W-1:0] rom_addr_d, rom_addr_q;
    logic              v1_d, v1_q;
    logic [3:0]        index_d, index_q;
    logic              hit_d, hit_q;
    logic              vsync_q;
    logic [DIV_W-1:0]  div_d, div_q;
    logic [1:0]        frame_d, frame_q;

    // Stage 0/1 next state: box test in 11 bits so a sprite near column 1023 never wraps.
    always_comb begin
        col_s    = DrawX - PacX;
        row_s    = DrawY - PacY;
        in_box_s = blank_n
                 & ({1'b0, DrawX} >= {1'b0, PacX})
                 & ({1'b0, DrawX} <  ({1'b0, PacX} + SPR_W11))
                 & ({1'b0, DrawY} >= {1'b0, PacY})
                 & ({1'b0, DrawY} <  ({1'b0, PacY} + SPR_H11));
        v1_d     = in_box_s;
        if (in_box_s) begin
            rom_addr_d = ADDR_W'(((32'(dir) * NUM_FRAMES + 32'(frame_q)) * SPR_H
                                  + 32'(row_s)) * SPR_W + 32'(col_s));
        end else begin
            rom_addr_d = rom_addr_q;
        end
    end

    // Stage 2 next state: the ROM answer is only meaningful when stage 1 was inside the box.
    always_comb begin
        if (v1_q) begin
            index_d = rom_data;
            hit_d   = (rom_data != TRANS_V);
        end else begin
            index_d = 4'd0;
            hit_d   = 1'b0;
        end
    end

    // Animation next state: steps only on vsync rising edges while moving.
    always_comb begin
        div_d     = div_q;
        frame_d   = frame_q;
        vs_edge_s = vsync & ~vsync_q;
        if (vs_edge_s && moving) begin
            if (div_q == DIV_LAST) begin
                div_d   = '0;
                frame_d = (frame_q == FRAME_LAST) ? 2'd0 : (frame_q + 2'd1);
            end else begin
                div_d   = div_q + DIV_W'(1);
            end
        end else begin
            div_d   = div_q;
            frame_d = frame_q;
        end
    end

    // State registers; reset also discards anything in the pixel pipeline.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr_q <= '0;
            v1_q       <= 1'b0;
            index_q    <= 4'd0;
            hit_q      <= 1'b0;
            vsync_q    <= 1'b0;
            div_q      <= '0;
            frame_q    <= 2'd0;
        end else begin
            rom_addr_q <= rom_addr_d;
            v1_q       <= v1_d;
            index_q    <= index_d;
            hit_q      <= hit_d;
            vsync_q    <= vsync;
            div_q      <= div_d;
            frame_q    <= frame_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign index    = index_q;
    assign hit      = hit_q;
    assign frame    = frame_q;

endmodule

// File: tb/tb_packman_sprite_fetch.sv
// Directed bench for packman_sprite_fetch: vector tables for addressing/hit logic,
// hand sequences for animation, pipeline latency and reset corner cases.
module tb_packman_sprite_fetch;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [9:0]  DrawX, DrawY, PacX, PacY;
    logic        blank_n, vsync, moving;
    logic [1:0]  dir;
    logic [11:0] rom_addr;
    logic [3:0]  rom_data, index;
    logic        hit;
    logic [1:0]  frame;

    int checks = 0;
    int errors = 0;

    packman_sprite_fetch dut (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank_n(blank_n),
        .vsync(vsync), .PacX(PacX), .PacY(PacY), .dir(dir), .moving(moving),
        .rom_addr(rom_addr), .rom_data(rom_data), .index(index), .hit(hit), .frame(frame)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [9:0]  dx, dy;
        logic        bl;
        logic [9:0]  px, py;
        logic [1:0]  dr;
        logic [3:0]  rd;
        logic [11:0] ea;
        logic [3:0]  ei;
        logic        eh;
    } vec_t;

    vec_t ta[15];
    vec_t tb[4];

    function automatic vec_t mk(input int dx, input int dy, input int bl, input int px,
                                input int py, input int dr, input int rd, input int ea,
                                input int ei, input int eh);
        vec_t v;
        v.dx = 10'(dx); v.dy = 10'(dy); v.bl = 1'(bl); v.px = 10'(px); v.py = 10'(py);
        v.dr = 2'(dr);  v.rd = 4'(rd);  v.ea = 12'(ea); v.ei = 4'(ei); v.eh = 1'(eh);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_vec(input string tag, input vec_t v);
        @(negedge Clk);
        DrawX = v.dx; DrawY = v.dy; blank_n = v.bl; PacX = v.px; PacY = v.py;
        dir = v.dr; rom_data = v.rd;
        @(posedge Clk); #1;
        chk({tag, " rom_addr"}, 32'(rom_addr), 32'(v.ea));
        @(posedge Clk); #1;
        chk({tag, " index"}, 32'(index), 32'(v.ei));
        chk({tag, " hit"}, 32'(hit), 32'(v.eh));
    endtask

    task automatic pulse();
        @(negedge Clk) vsync = 1'b1;
        @(negedge Clk);
        @(negedge Clk) vsync = 1'b0;
        @(negedge Clk);
    endtask

    logic [9:0]  pxs[4] = '{10'd100, 10'd101, 10'd200, 10'd103};
    logic [11:0] pas[4] = '{12'd256, 12'd257, 12'd257, 12'd259};
    logic [3:0]  pis[4] = '{4'd1, 4'd2, 4'd0, 4'd4};
    logic        phs[4] = '{1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        //             dx    dy  bl  px    py  dr rd  addr  idx hit   (frame 0)
        ta[0]  = mk(100,  50, 1, 100,  50, 0, 5,    0, 5, 1);
        ta[1]  = mk(101,  50, 1, 100,  50, 0, 3,    1, 3, 1);
        ta[2]  = mk(100,  51, 1, 100,  50, 1, 8,  784, 8, 0);
        ta[3]  = mk(105,  55, 0, 100,  50, 0, 5,  784, 0, 0);
        ta[4]  = mk(116,  50, 1, 100,  50, 0, 5,  784, 0, 0);
        ta[5]  = mk( 99,  50, 1, 100,  50, 0, 5,  784, 0, 0);
        ta[6]  = mk(100,  66, 1, 100,  50, 0, 5,  784, 0, 0);
        ta[7]  = mk(115,  65, 1, 100,  50, 3, 7, 2559, 7, 1);
        ta[8]  = mk(1018,  0, 1, 1020,  0, 0, 4, 2559, 0, 0);
        ta[9]  = mk(1020,  0, 1, 1020,  0, 0, 4,    0, 4, 1);
        ta[10] = mk(1023,  0, 1, 1020,  0, 0, 4,    3, 4, 1);
        ta[11] = mk(  0,   0, 1, 1020,  0, 0, 4,    3, 0, 0);
        ta[12] = mk(  3,   0, 1, 1020,  0, 0, 4,    3, 0, 0);
        ta[13] = mk(1023,  5, 1, 1023,  0, 0, 2,   80, 2, 1);
        ta[14] = mk(1019,  0, 1, 1020,  0, 0, 4,   80, 0, 0);
        //                                              (frame 1)
        tb[0]  = mk(115,  65, 1, 100,  50, 2, 9, 2047, 9, 1);
        tb[1]  = mk(116,  65, 1, 100,  50, 2, 9, 2047, 0, 0);
        tb[2]  = mk(100,  50, 1, 100,  50, 2, 8, 1792, 8, 0);
        tb[3]  = mk(100,  50, 1, 100,  50, 0, 1,  256, 1, 1);

        Reset = 1'b1; DrawX = 10'd0; DrawY = 10'd0; blank_n = 1'b0; vsync = 1'b0;
        PacX = 10'd100; PacY = 10'd50; dir = 2'd0; moving = 1'b0; rom_data = 4'd0;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset rom_addr", 32'(rom_addr), 32'd0);
        chk("reset index", 32'(index), 32'd0);
        chk("reset hit", 32'(hit), 32'd0);
        chk("reset frame", 32'(frame), 32'd0);
        @(negedge Clk) Reset = 1'b0;

        for (int i = 0; i < 15; i++) apply_vec($sformatf("tA%0d", i), ta[i]);

        // Animation: frame steps every 4th rising edge while moving
        moving = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            pulse();
            chk($sformatf("anim edge%0d frame", k), 32'(frame), 32'((k / 4) % 3));
        end
        moving = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            pulse();
            chk($sformatf("hold edge%0d frame", k), 32'(frame), 32'd1);
        end

        for (int i = 0; i < 4; i++) apply_vec($sformatf("tB%0d", i), tb[i]);

        // Back-to-back pixels: result for pixel t appears exactly two edges after it is driven
        for (int t = 0; t < 5; t++) begin
            @(negedge Clk);
            if (t < 4) begin
                DrawX = pxs[t]; DrawY = 10'd50; PacX = 10'd100; PacY = 10'd50;
                dir = 2'd0; blank_n = 1'b1;
            end
            if (t >= 1) rom_data = 4'(t);
            @(posedge Clk); #1;
            if (t < 4) chk($sformatf("pipe%0d rom_addr", t), 32'(rom_addr), 32'(pas[t]));
            if (t >= 1) begin
                chk($sformatf("pipe%0d index", t - 1), 32'(index), 32'(pis[t - 1]));
                chk($sformatf("pipe%0d hit", t - 1), 32'(hit), 32'(phs[t - 1]));
            end
        end

        // Reset mid-stream with a valid pixel in flight
        @(negedge Clk) DrawX = 10'd104; rom_data = 4'd6;
        @(negedge Clk) Reset = 1'b1;
        @(posedge Clk); #1;
        chk("midrst hit", 32'(hit), 32'd0);
        chk("midrst index", 32'(index), 32'd0);
        chk("midrst frame", 32'(frame), 32'd0);
        chk("midrst rom_addr", 32'(rom_addr), 32'd0);
        @(negedge Clk) Reset = 1'b0;
        @(posedge Clk); #1;
        chk("postrst c1 hit", 32'(hit), 32'd0);
        chk("postrst c1 rom_addr", 32'(rom_addr), 32'd4);
        @(posedge Clk); #1;
        chk("postrst c2 hit", 32'(hit), 32'd1);
        chk("postrst c2 index", 32'(index), 32'd6);

        // Reset on the same edge as vsync rise clears a part-filled divider
        moving = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            pulse();
            chk($sformatf("predrst edge%0d frame", k), 32'(frame), 32'd0);
        end
        @(negedge Clk) begin Reset = 1'b1; vsync = 1'b1; end
        @(posedge Clk); #1;
        chk("vsrst frame", 32'(frame), 32'd0);
        @(negedge Clk) begin Reset = 1'b0; vsync = 1'b0; end
        for (int k = 1; k <= 4; k++) begin
            pulse();
            chk($sformatf("postvs edge%0d frame", k), 32'(frame), (k == 4) ? 32'd1 : 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
